// File: rtl/iram_port_arbiter.sv
// ----------------------------------------------------------------------------
// iram_port_arbiter
//
// Shares the single-port bytecode instruction RAM between three requesters:
//   ld : host bytecode loader (read/write, can lock the port for bursts)
//   fe : JIT opcode/parameter fetch path (read-only)
//   bf : branch-fixup reader (read-only)
// One RAM access is granted per cycle. Grant order: locked loader, aged fetch,
// aged fixup, then fixed priority ld > fe > bf. Read data returns one cycle
// after the grant on the shared rdata bus, qualified by the owner's rvalid.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   ld_req/we/lock/addr/wdata  loader request; ld_gnt, ld_rvalid
//   fe_req/addr                fetch request;  fe_gnt, fe_rvalid
//   bf_req/addr                fixup request;  bf_gnt, bf_rvalid
//   rdata                      shared read data (ram_rdata pass-through)
//   ram_en/we/addr/wdata       RAM command port; ram_rdata RAM read data
// ----------------------------------------------------------------------------
module iram_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic              ld_lock,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    input  logic              fe_req,
    input  logic [ADDR_W-1:0] fe_addr,
    output logic              fe_gnt,
    output logic              fe_rvalid,
    input  logic              bf_req,
    input  logic [ADDR_W-1:0] bf_addr,
    output logic              bf_gnt,
    output logic              bf_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    // Read-owner encoding: which requester the data on rdata belongs to.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_FE   = 2'd2;
    localparam logic [1:0] OWN_BF   = 2'd3;

    logic [AGE_W-1:0] age_fe_q, age_fe_d;
    logic [AGE_W-1:0] age_bf_q, age_bf_d;
    logic             lock_q, lock_d;
    logic [1:0]       owner_q, owner_d;

    // ------------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ld_gnt = 1'b0;
        fe_gnt = 1'b0;
        bf_gnt = 1'b0;
        // Grants are suppressed while reset is held so the RAM stays idle.
        if (reset) begin
            if (lock_q) begin
                // Locked: the port belongs to the loader even if it idles.
                ld_gnt = ld_req;
            end else if (fe_req && (age_fe_q == AGE_MAX)) begin
                fe_gnt = 1'b1;
            end else if (bf_req && (age_bf_q == AGE_MAX)) begin
                bf_gnt = 1'b1;
            end else if (ld_req) begin
                ld_gnt = 1'b1;
            end else if (fe_req) begin
                fe_gnt = 1'b1;
            end else if (bf_req) begin
                bf_gnt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // RAM port mux
    // ------------------------------------------------------------------------
    always_comb begin
        ram_en    = ld_gnt | fe_gnt | bf_gnt;
        ram_we    = ld_gnt & ld_we;
        ram_addr  = '0;
        ram_wdata = '0;
        if (ld_gnt) begin
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
        end else if (fe_gnt) begin
            ram_addr = fe_addr;
        end else if (bf_gnt) begin
            ram_addr = bf_addr;
        end
    end

    assign rdata     = ram_rdata;
    assign ld_rvalid = (owner_q == OWN_LD);
    assign fe_rvalid = (owner_q == OWN_FE);
    assign bf_rvalid = (owner_q == OWN_BF);

    // ------------------------------------------------------------------------
    // Next-state logic: ages, lock, read owner
    // ------------------------------------------------------------------------
    always_comb begin
        age_fe_d = age_fe_q;
        age_bf_d = age_bf_q;
        lock_d   = lock_q;
        owner_d  = OWN_NONE;

        // Age counts consecutive un-granted cycles of a held request.
        if (!fe_req || fe_gnt) begin
            age_fe_d = '0;
        end else if (age_fe_q != AGE_MAX) begin
            age_fe_d = age_fe_q + AGE_W'(1);
        end

        if (!bf_req || bf_gnt) begin
            age_bf_d = '0;
        end else if (age_bf_q != AGE_MAX) begin
            age_bf_d = age_bf_q + AGE_W'(1);
        end

        // Dropping either req or lock releases the port at the end of this
        // cycle; a locked cycle with ld_req low therefore idles exactly once.
        if (!ld_req || !ld_lock) begin
            lock_d = 1'b0;
        end else if (ld_gnt) begin
            lock_d = 1'b1;
        end

        if (ram_en && !ram_we) begin
            if (ld_gnt) begin
                owner_d = OWN_LD;
            end else if (fe_gnt) begin
                owner_d = OWN_FE;
            end else begin
                owner_d = OWN_BF;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_fe_q <= '0;
            age_bf_q <= '0;
            lock_q   <= 1'b0;
            owner_q  <= OWN_NONE;
        end else begin
            age_fe_q <= age_fe_d;
            age_bf_q <= age_bf_d;
            lock_q   <= lock_d;
            owner_q  <= owner_d;
        end
    end

endmodule

// File: tb/tb_iram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_iram_port_arbiter
//
// Directed bench for iram_port_arbiter with a small behavioural RAM model.
// Each scenario task drives inputs just after a rising edge and compares
// outputs mid-cycle against hand-computed values.
// ----------------------------------------------------------------------------
module tb_iram_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_req, ld_we, ld_lock;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt, ld_rvalid;
    logic              fe_req;
    logic [ADDR_W-1:0] fe_addr;
    logic              fe_gnt, fe_rvalid;
    logic              bf_req;
    logic [ADDR_W-1:0] bf_addr;
    logic              bf_gnt, bf_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Preload path into the RAM model, used only while the DUT is idle.
    logic              pl_we;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(7)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt), .fe_rvalid(fe_rvalid),
        .bf_req(bf_req), .bf_addr(bf_addr), .bf_gnt(bf_gnt), .bf_rvalid(bf_rvalid),
        .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM: read data one cycle after a read enable.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = '0; ld_wdata = '0;
        fe_req = 0; fe_addr = '0; bf_req = 0; bf_addr = '0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_we = 1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 0;
    endtask

    // All outputs held at zero while reset is asserted, even with requests up.
    task automatic test_reset();
        reset = 0; pl_we = 0; pl_addr = '0; pl_data = '0; ram_rdata = '0;
        idle_inputs();
        ld_req = 1; fe_req = 1; bf_req = 1; ld_addr = 12'h123; ld_wdata = 8'h77;
        tick(); tick();
        #1;
        if ({ld_gnt, fe_gnt, bf_gnt, ld_rvalid, fe_rvalid, bf_rvalid,
             ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
            $display("FAIL reset_outputs: gnt=%b%b%b rv=%b%b%b en=%b we=%b addr=%h wd=%h, want all 0",
                     ld_gnt, fe_gnt, bf_gnt, ld_rvalid, fe_rvalid, bf_rvalid,
                     ram_en, ram_we, ram_addr, ram_wdata);
            n_err++;
        end
        n_vec++;
        idle_inputs();
        tick();
        reset = 1;
        tick();
        preload(12'h010, 8'hB6);
        preload(12'h030, 8'h11);
        preload(12'h040, 8'h22);
    endtask

    task automatic test_single_read();
        fe_req = 1; fe_addr = 12'h010;
        #1;
        if (fe_gnt !== 1'b1 || ram_addr !== 12'h010 || ram_en !== 1'b1 || ram_we !== 1'b0) begin
            $display("FAIL single_grant: fe_gnt=%b ram_addr=%h en=%b we=%b, want 1 010 1 0",
                     fe_gnt, ram_addr, ram_en, ram_we);
            n_err++;
        end
        n_vec++;
        tick();
        fe_req = 0;
        #1;
        if (fe_rvalid !== 1'b1 || rdata !== 8'hB6 || ld_rvalid !== 1'b0 || bf_rvalid !== 1'b0) begin
            $display("FAIL single_rvalid: fe_rv=%b rdata=%h ld_rv=%b bf_rv=%b, want 1 b6 0 0",
                     fe_rvalid, rdata, ld_rvalid, bf_rvalid);
            n_err++;
        end
        n_vec++;
        tick();
        if (fe_rvalid !== 1'b0) begin
            $display("FAIL single_rvalid_pulse: fe_rvalid=%b, want 0", fe_rvalid);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_priority();
        ld_req = 1; ld_we = 1; ld_addr = 12'h020; ld_wdata = 8'h5A;
        fe_req = 1; fe_addr = 12'h030;
        bf_req = 1; bf_addr = 12'h040;
        #1;
        if (ld_gnt !== 1'b1 || fe_gnt !== 1'b0 || bf_gnt !== 1'b0 || ram_we !== 1'b1 || ram_wdata !== 8'h5A) begin
            $display("FAIL prio_ld: gnt=%b%b%b we=%b wd=%h, want 100 1 5a",
                     ld_gnt, fe_gnt, bf_gnt, ram_we, ram_wdata);
            n_err++;
        end
        n_vec++;
        tick();
        ld_req = 0; ld_we = 0;
        #1;
        if (fe_gnt !== 1'b1 || bf_gnt !== 1'b0 || ld_rvalid !== 1'b0 || ram_addr !== 12'h030) begin
            $display("FAIL prio_fe: fe_gnt=%b bf_gnt=%b ld_rv=%b addr=%h, want 1 0 0 030",
                     fe_gnt, bf_gnt, ld_rvalid, ram_addr);
            n_err++;
        end
        n_vec++;
        tick();
        fe_req = 0;
        #1;
        // Grant to bf and rvalid to fe land in the same cycle.
        if (bf_gnt !== 1'b1 || fe_rvalid !== 1'b1 || rdata !== 8'h11 || ram_addr !== 12'h040) begin
            $display("FAIL prio_bf: bf_gnt=%b fe_rv=%b rdata=%h addr=%h, want 1 1 11 040",
                     bf_gnt, fe_rvalid, rdata, ram_addr);
            n_err++;
        end
        n_vec++;
        tick();
        bf_req = 0;
        #1;
        if (bf_rvalid !== 1'b1 || rdata !== 8'h22 || fe_rvalid !== 1'b0 || mem[12'h020] !== 8'h5A) begin
            $display("FAIL prio_bf_rvalid: bf_rv=%b rdata=%h fe_rv=%b mem[020]=%h, want 1 22 0 5a",
                     bf_rvalid, rdata, fe_rvalid, mem[12'h020]);
            n_err++;
        end
        n_vec++;
        tick();
    endtask

    task automatic test_aging();
        int c;
        ld_req = 1; ld_addr = 12'h100; fe_req = 1; fe_addr = 12'h010;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (fe_gnt !== (k == 8) || ld_gnt !== (k != 8)) begin
                $display("FAIL aging_fe_cycle%0d: fe_gnt=%b ld_gnt=%b, want %b %b",
                         k, fe_gnt, ld_gnt, (k == 8), (k != 8));
                n_err++;
            end
            n_vec++;
            tick();
        end
        idle_inputs();
        tick();
        // All three requesting: fe ages out at cycle 8, bf (also aged) at 9.
        ld_req = 1; fe_req = 1; bf_req = 1; bf_addr = 12'h040;
        c = 21;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (bf_gnt === 1'b1) begin
                c = k;
                break;
            end
            tick();
        end
        if (c != 9) begin
            $display("FAIL aging_bf: first bf_gnt at cycle %0d, want 9", c);
            n_err++;
        end
        n_vec++;
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_lock_burst();
        fe_req = 1; fe_addr = 12'h010;
        for (int i = 0; i < 32; i++) begin
            ld_req = 1; ld_we = 1; ld_lock = 1;
            ld_addr = ADDR_W'(i); ld_wdata = DATA_W'(i) ^ 8'hA5;
            #1;
            if (ld_gnt !== 1'b1 || fe_gnt !== 1'b0) begin
                $display("FAIL lock_beat%0d: ld_gnt=%b fe_gnt=%b, want 1 0", i, ld_gnt, fe_gnt);
                n_err++;
            end
            n_vec++;
            tick();
        end
        ld_req = 0; ld_we = 0; ld_lock = 0;
        #1;
        if (ld_gnt !== 1'b0 || fe_gnt !== 1'b0 || ram_en !== 1'b0) begin
            $display("FAIL lock_idle: ld_gnt=%b fe_gnt=%b en=%b, want 0 0 0", ld_gnt, fe_gnt, ram_en);
            n_err++;
        end
        n_vec++;
        tick();
        if (fe_gnt !== 1'b1) begin
            $display("FAIL lock_release: fe_gnt=%b, want 1", fe_gnt);
            n_err++;
        end
        n_vec++;
        fe_req = 0;
        tick();
        if (mem[12'h005] !== 8'hA0 || mem[12'h01F] !== 8'hBA) begin
            $display("FAIL lock_data: mem[005]=%h mem[01f]=%h, want a0 ba", mem[12'h005], mem[12'h01F]);
            n_err++;
        end
        n_vec++;
        tick();
    endtask

    task automatic test_withdrawn();
        fe_req = 1; fe_addr = 12'h010; bf_req = 1; bf_addr = 12'h040;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (fe_gnt !== 1'b1 || bf_gnt !== 1'b0) begin
                $display("FAIL withdraw_cycle%0d: fe_gnt=%b bf_gnt=%b, want 1 0", k, fe_gnt, bf_gnt);
                n_err++;
            end
            n_vec++;
            tick();
        end
        if (dut.age_bf_q !== 3'd2) begin
            $display("FAIL withdraw_age_held: age_bf=%0d, want 2", dut.age_bf_q);
            n_err++;
        end
        n_vec++;
        bf_req = 0;
        #1;
        if (bf_gnt !== 1'b0) begin
            $display("FAIL withdraw_no_gnt: bf_gnt=%b, want 0", bf_gnt);
            n_err++;
        end
        n_vec++;
        tick();
        if (dut.age_bf_q !== 3'd0) begin
            $display("FAIL withdraw_age_clear: age_bf=%0d, want 0", dut.age_bf_q);
            n_err++;
        end
        n_vec++;
        fe_req = 0;
        tick();
    endtask

    // Reset asserted the cycle after a read grant: the read never returns.
    task automatic test_reset_mid_read();
        fe_req = 1; fe_addr = 12'h030;
        #1;
        if (fe_gnt !== 1'b1) begin
            $display("FAIL midread_gnt: fe_gnt=%b, want 1", fe_gnt);
            n_err++;
        end
        n_vec++;
        tick();
        reset = 0;
        fe_req = 0;
        #1;
        if (fe_rvalid !== 1'b0) begin
            $display("FAIL midread_rvalid_in_reset: fe_rvalid=%b, want 0", fe_rvalid);
            n_err++;
        end
        n_vec++;
        tick();
        reset = 1;
        #1;
        if ({ld_gnt, fe_gnt, bf_gnt, ld_rvalid, fe_rvalid, bf_rvalid,
             ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
            $display("FAIL midread_release: gnt=%b%b%b rv=%b%b%b en=%b addr=%h, want all 0",
                     ld_gnt, fe_gnt, bf_gnt, ld_rvalid, fe_rvalid, bf_rvalid, ram_en, ram_addr);
            n_err++;
        end
        n_vec++;
        tick();
        if (fe_rvalid !== 1'b0) begin
            $display("FAIL midread_after: fe_rvalid=%b, want 0", fe_rvalid);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_aging();
        test_lock_burst();
        test_withdrawn();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
